// File: rtl/piece_scheduler.sv
// 7-bag Tetris piece generator feeding a preview FIFO; optional bag rule under `PIECE_BAG_EN.
// One draw attempt per cycle (push within RETRY_MAX+1 cycles); pops only while piece_valid, draws stop when full.
module piece_scheduler #(
   parameter int unsigned DEPTH     = 3,
   parameter logic [15:0] SEED      = 16'hACE1,
   parameter int unsigned RETRY_MAX = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       gameover,
   input  logic       piece_req,
   output logic       piece_valid,
   output logic [2:0] piece_idx,
   output logic [2:0] next_idx,
   output logic [2:0] queue_count,
   output logic       busy
);

   localparam int RW = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);
   localparam logic [RW-1:0] RMAX   = RW'(RETRY_MAX);
   localparam logic [2:0]    DEPTH3 = 3'(DEPTH);
   localparam logic [2:0]    LAST   = 3'(DEPTH - 1);

   typedef enum logic [1:0] {IDLE, DRAW, FULL, OVER} state_t;

   state_t         state, state_nxt;
   logic [15:0]    lfsr;
   logic           fb;
   logic [2:0]     cand, fallback, push_dat;
   logic           accept, push, pop, flush;
   logic [RW-1:0]  retry, retry_nxt;
   logic [2:0]     mem [0:7];
   logic [2:0]     rd_ptr, wr_ptr, count, count_nxt;
`ifdef PIECE_BAG_EN
   logic [6:0]     bag, bag_nxt, bag_set;
   logic [7:0]     bag_ext;
`endif

   function automatic logic [2:0] ptr_inc(input logic [2:0] p);
      return (p == LAST) ? 3'd0 : p + 3'd1;
   endfunction

   assign fb   = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
   assign cand = lfsr[2:0];

`ifdef PIECE_BAG_EN
   // Bit 7 is forced set so candidate 7 is rejected by the same lookup.
   assign bag_ext = {1'b1, bag};
   assign accept  = !bag_ext[cand];
   always_comb begin
      fallback = 3'd0;
      for (int i = 6; i >= 0; i--)
         if (!bag[i]) fallback = 3'(i);
   end
`else
   assign accept   = (cand != 3'd7);
   assign fallback = 3'd0;
`endif

   always_comb begin
      state_nxt = state;
      push      = 1'b0;
      pop       = 1'b0;
      flush     = 1'b0;
      push_dat  = cand;
      retry_nxt = retry;
      count_nxt = count;
      if (start) begin
         flush     = 1'b1;
         retry_nxt = '0;
         count_nxt = 3'd0;
         state_nxt = DRAW;
      end else if (gameover && state != IDLE) begin
         state_nxt = OVER;
      end else begin
         case (state)
            OVER: state_nxt = (count == DEPTH3) ? FULL : DRAW;
            DRAW, FULL: begin
               pop = piece_req && (count != 3'd0);
               if (state == DRAW) begin
                  if (accept) begin
                     push = 1'b1;
                  end else if (retry == RMAX) begin
                     push     = 1'b1;
                     push_dat = fallback;
                  end else begin
                     retry_nxt = retry + 1'b1;
                  end
                  if (push) retry_nxt = '0;
               end
               count_nxt = count + {2'b0, push} - {2'b0, pop};
               state_nxt = (count_nxt == DEPTH3) ? FULL : DRAW;
            end
            default: ;
         endcase
      end
   end

`ifdef PIECE_BAG_EN
   always_comb begin
      bag_set = bag | (7'b1 << push_dat);
      bag_nxt = bag;
      if (start)
         bag_nxt = 7'b0;
      else if (push)
         bag_nxt = (bag_set == 7'h7F) ? 7'b0 : bag_set;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) bag <= 7'b0;
      else     bag <= bag_nxt;
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         lfsr   <= SEED;
         retry  <= '0;
         rd_ptr <= 3'd0;
         wr_ptr <= 3'd0;
         count  <= 3'd0;
         for (int i = 0; i < 8; i++) mem[i] <= 3'd0;
      end else begin
         state <= state_nxt;
         lfsr  <= {lfsr[14:0], fb};
         retry <= retry_nxt;
         count <= count_nxt;
         if (flush) begin
            rd_ptr <= 3'd0;
            wr_ptr <= 3'd0;
         end else begin
            if (push) begin
               mem[wr_ptr] <= push_dat;
               wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
         end
      end
   end

   assign piece_valid = (count != 3'd0) && (state == DRAW || state == FULL) && !gameover;
   assign piece_idx   = (count != 3'd0) ? mem[rd_ptr] : 3'd0;
   assign next_idx    = (count >= 3'd2) ? mem[ptr_inc(rd_ptr)] : 3'd0;
   assign queue_count = count;
   assign busy        = (state == DRAW);

endmodule

// File: doc/piece_scheduler.md
Name: piece_scheduler

Overview:
- Sequences Tetris piece generation: draws indices 0-6 from an internal LFSR under a 7-bag rule and buffers them in a preview FIFO.
- Serves the game-control FSM over a valid/req handshake; also exposes the next piece for the preview display.
- Sits between the game FSM and the board/spawn logic; replaces direct use of the free-running index counter.

Parameters:
- DEPTH, 3, preview FIFO entries (2..7).
- SEED, 16'hACE1, LFSR value loaded on rst; must be nonzero.
- RETRY_MAX, 4, failed draw attempts allowed before fallback pick.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  sync pulse: begin new game, flush queue and bag.
- gameover  in  1  level: freeze piece delivery.
- piece_req  in  1  consumer pops head when piece_valid=1.
- piece_valid  out  1  head entry available.
- piece_idx  out  3  head piece index, 0-6.
- next_idx  out  3  entry behind head; 0 if count<2.
- queue_count  out  3  current FIFO occupancy.
- busy  out  1  1 while in DRAW.

Behaviour:
- Reset (async, rst=1): state IDLE, LFSR=SEED, bag=7'b0, FIFO empty, retry=0. All outputs 0.
- LFSR: 16-bit Fibonacci, shift left each clk in every state except reset. feedback = b15^b13^b12^b10. Candidate cand = lfsr[2:0].
- States:
  - IDLE: wait for start.
  - DRAW: one attempt per cycle.
  - FULL: queue_count==DEPTH.
  - OVER: gameover=1.
- start (any state, highest priority after rst): FIFO flushed, bag=0, retry=0, next state DRAW. LFSR is not reseeded.
- Draw attempt (DRAW only):
  - Accept if cand!=7 and bag[cand]==0 → push cand, set bag[cand], retry=0.
  - Otherwise retry+1.
  - If retry==RETRY_MAX, push the lowest-numbered unused index instead, then retry=0.
  - Worst-case latency per push = RETRY_MAX+1 cycles.
- Bag: when a push makes bag==7'h7F, bag clears in the same cycle. Every aligned group of 7 pushes since start is therefore a permutation of 0-6.
- Transitions:
  - DRAW→FULL when a push makes count==DEPTH.
  - FULL→DRAW on pop.
- Pop: piece_req && piece_valid → head removed. piece_idx/next_idx update next cycle. piece_req with piece_valid=0 is ignored.
- Simultaneous push and pop: both happen, count unchanged. Pushing into an empty FIFO gives piece_valid=1 the following cycle (1-cycle latency).
- piece_valid = (count!=0) && state!=OVER && state!=IDLE.
- gameover=1 (not start): go to OVER. No pushes or pops, piece_valid=0, queue and bag retained. gameover deasserted returns to DRAW or FULL by count.
- start together with gameover: start wins, giving DRAW with an empty queue.
- queue_count never exceeds DEPTH. No push occurs when full.

Optional Feature:
- Macro PIECE_BAG_EN.
- Defined: 7-bag rule as above.
- Undefined: bag logic removed. Accept any cand!=7. After RETRY_MAX rejects, push 0. Bag permutation guarantee absent. All other timing is identical.

Test Plan:
- rst, then start at cycle 0 → busy=1. queue_count reaches DEPTH=3 within 15 cycles, piece_valid=1, busy=0.
- 70 pops with piece_req held 1 (PIECE_BAG_EN) → each consecutive group of 7 indices is a permutation of {0..6}. piece_idx is never 7.
- FIFO at 3, single piece_req cycle → count 2 next cycle, piece_idx equals the prior next_idx, DRAW refills to 3.
- gameover=1 with count=3, piece_req=1 for 10 cycles → piece_valid=0, count stays 3. Release → piece_valid=1, same piece_idx as before.
- start and gameover asserted same cycle with count=3 → next cycle count=0, state DRAW, piece_valid=0.
- rst asserted mid-DRAW (async, between edges) → outputs 0 immediately. After release, LFSR restarts from 16'hACE1, so the first 7 pieces after start match a golden run.
